// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter and its picker.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } dmem_state_e;

  localparam int unsigned NREQ      = 2;
  localparam int unsigned AW_DEF    = 32;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned DEPTH_DEF = 64;

endpackage

// File: rtl/dmem_rr_pick.sv
// Round-robin winner selection: a lone request wins, a tie goes to the
// requester that did not win last time.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [NREQ-1:0] Req,
  input  logic            Last,
  output logic            Win,
  output logic            WinValid
);

  always_comb begin
    WinValid = |Req;
    case (Req)
      2'b01:   Win = 1'b0;
      2'b10:   Win = 1'b1;
      2'b11:   Win = ~Last;
      default: Win = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin front end for the single-port data memory:
// latch one request in IDLE, strobe the memory in ISSUE, respond in RESP.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    Req,
  input  logic [NREQ-1:0]    ReqWrite,
  input  logic [NREQ*AW-1:0] ReqAddress,
  input  logic [NREQ*DW-1:0] ReqWriteData,
  output logic [NREQ-1:0]    Gnt,
  output logic [NREQ-1:0]    Done,
  output logic [NREQ-1:0]    Err,
  output logic [DW-1:0]      RespData,
  output logic               Busy,
  output logic [AW-1:0]      MemAddress,
  output logic               MemWrite,
  output logic               MemRead,
  output logic [DW-1:0]      MemWriteData,
  input  logic [DW-1:0]      MemReadData
);

  // Wide enough that neither the address nor DEPTH loses bits in the compare.
  localparam int unsigned CW = AW + 33;

  dmem_state_e     r_state;
  logic            r_last;
  logic            r_win;
  logic            r_write;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW-1:0]   r_resp;

  logic            w_win;
  logic            w_win_valid;
  logic            w_in_range;
  logic            w_issue;
  logic            w_resp;
  logic [NREQ-1:0] w_win_onehot;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;

  dmem_rr_pick u_pick (
    .Req      (Req),
    .Last     (r_last),
    .Win      (w_win),
    .WinValid (w_win_valid)
  );

  assign w_sel_addr   = w_win ? ReqAddress[2*AW-1:AW]   : ReqAddress[AW-1:0];
  assign w_sel_wdata  = w_win ? ReqWriteData[2*DW-1:DW] : ReqWriteData[DW-1:0];
  assign w_in_range   = CW'(r_mem_addr) < CW'(DEPTH);
  assign w_issue      = (r_state == ISSUE);
  assign w_resp       = (r_state == RESP);
  assign w_win_onehot = r_win ? 2'b10 : 2'b01;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_win       <= 1'b0;
      r_write     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_resp      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_win_valid) begin
            r_win       <= w_win;
            r_last      <= w_win;
            r_write     <= ReqWrite[w_win];
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!w_in_range)
            r_resp <= '0;
          else if (!r_write)
            r_resp <= MemReadData;
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Busy         = (r_state != IDLE);
  assign Gnt          = w_issue ? w_win_onehot : '0;
  assign Done         = w_resp ? w_win_onehot : '0;
  assign Err          = (w_resp && !w_in_range) ? w_win_onehot : '0;
  assign MemWrite     = w_issue && w_in_range && r_write;
  assign MemRead      = w_issue && w_in_range && !r_write;
  assign MemAddress   = r_mem_addr;
  assign MemWriteData = r_mem_wdata;
  assign RespData     = r_resp;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-level model with a reference memory.
module tb_dmem_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    req_v;
  logic [1:0]    req_wr;
  logic [31:0]   req_a [2];
  logic [31:0]   req_d [2];
  logic [1:0]    Gnt, Done, Err;
  logic [DW-1:0] RespData, MemWriteData, MemReadData;
  logic [AW-1:0] MemAddress;
  logic          Busy, MemWrite, MemRead;

  dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Req          (req_v),
    .ReqWrite     (req_wr),
    .ReqAddress   ({req_a[1], req_a[0]}),
    .ReqWriteData ({req_d[1], req_d[0]}),
    .Gnt          (Gnt),
    .Done         (Done),
    .Err          (Err),
    .RespData     (RespData),
    .Busy         (Busy),
    .MemAddress   (MemAddress),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemWriteData (MemWriteData),
    .MemReadData  (MemReadData)
  );

  // 64-word memory device; decodes only the low address bits like the real one.
  logic [31:0] mem [64];
  bit          mem_load = 1'b1;
  assign MemReadData = mem[MemAddress[5:0]];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 0) ? 32'd63 : 32'd0;
    end else if (MemWrite) begin
      mem[MemAddress[5:0]] <= MemWriteData;
    end
  end

  // Transaction-level model: one accepted request, timed by cycle offsets.
  int          cyc;
  bit          t_act;
  int          t_n, t_w;
  bit          t_wr, t_ok;
  logic [31:0] t_a, t_d;
  int          m_last;
  logic [31:0] m_hold_a, m_hold_d, m_resp;
  logic [31:0] ref_mem [64];
  bit          auto_mode;
  bit          pend [2];
  logic [1:0]  gnt_log [$];
  int          n_chk, n_fail;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int phase();
    return t_act ? (cyc - t_n) : -1;
  endfunction

  task automatic model_reset();
    t_act    = 1'b0;
    m_last   = 1;
    m_hold_a = '0;
    m_hold_d = '0;
    m_resp   = '0;
  endtask

  task automatic check_outputs();
    int k;
    logic [1:0] oh;
    k  = phase();
    oh = (t_w == 1) ? 2'b10 : 2'b01;
    check("busy",       Busy, (k == 1 || k == 2));
    check("gnt",        Gnt, (k == 1) ? oh : 2'b00);
    check("mem_write",  MemWrite, (k == 1 && t_ok && t_wr));
    check("mem_read",   MemRead, (k == 1 && t_ok && !t_wr));
    check("one_strobe", MemWrite & MemRead, 0);
    check("mem_addr",   MemAddress, m_hold_a);
    check("mem_wdata",  MemWriteData, m_hold_d);
    check("done",       Done, (k == 2) ? oh : 2'b00);
    check("err",        Err, (k == 2 && !t_ok) ? oh : 2'b00);
    check("resp_data",  RespData, m_resp);
    if (Gnt != 2'b00) gnt_log.push_back(Gnt);
  endtask

  task automatic model_advance();
    int k;
    bit idle;
    k    = phase();
    idle = !t_act;
    if (k == 1) begin
      if (t_ok && t_wr) ref_mem[t_a[5:0]] = t_d;
      if (!t_ok)      m_resp = '0;
      else if (!t_wr) m_resp = ref_mem[t_a[5:0]];
      pend[t_w] = 1'b0;
    end
    if (k == 2) t_act = 1'b0;
    if (idle && req_v != 2'b00) begin
      int w;
      w = (req_v == 2'b11) ? (1 - m_last) : (req_v[1] ? 1 : 0);
      m_last   = w;
      t_act    = 1'b1;
      t_n      = cyc;
      t_w      = w;
      t_wr     = req_wr[w];
      t_a      = req_a[w];
      t_d      = req_d[w];
      t_ok     = (t_a < DEPTH);
      m_hold_a = t_a;
      m_hold_d = t_d;
    end
    cyc++;
  endtask

  task automatic drive_random();
    int k;
    k = phase();
    for (int i = 0; i < 2; i++) begin
      if (pend[i] && k == 1 && t_w == i) begin
        req_wr[i] = 1'($urandom_range(0, 1));
        req_a[i]  = $urandom();
        req_d[i]  = $urandom();
      end else if (pend[i] && !t_act && $urandom_range(0, 7) == 0) begin
        pend[i] = 1'b0;
      end else if (!pend[i] && $urandom_range(0, 1) == 0) begin
        pend[i]   = 1'b1;
        req_wr[i] = 1'($urandom_range(0, 1));
        req_a[i]  = ($urandom_range(0, 7) == 0) ? ($urandom() | 32'h40) : 32'($urandom_range(0, 63));
        req_d[i]  = $urandom();
      end
      req_v[i] = pend[i];
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle();
    if (auto_mode) drive_random();
    @(negedge clk);
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_req(input int i, input bit v, input bit wr, input logic [31:0] a, input logic [31:0] d);
    req_v[i]  = v;
    req_wr[i] = wr;
    req_a[i]  = a;
    req_d[i]  = d;
  endtask

  task automatic txn(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
    set_req(i, 1'b1, wr, a, d);
    run(2);
    req_v[i] = 1'b0;
    run(2);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    auto_mode = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = (i == 0) ? 32'd63 : 32'd0;
    req_v = 2'b00;
    req_wr = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_a[i] = '0;
      req_d[i] = '0;
    end
    model_reset();

    repeat (2) @(posedge clk);
    mem_load = 1'b0;
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Store then load back through requester 0.
    txn(0, 1'b1, 32'd5, 32'hDEADBEEF);
    txn(0, 1'b0, 32'd5, 32'd0);
    check("t1_load_back", RespData, 32'hDEADBEEF);

    // Requester 1 loads the initialised word 0.
    txn(1, 1'b0, 32'd0, 32'd0);
    check("t2_load_word0", RespData, 32'd63);

    // Both requesting continuously: grants must alternate.
    gnt_log.delete();
    set_req(0, 1'b1, 1'b0, 32'd10, 32'd0);
    set_req(1, 1'b1, 1'b0, 32'd20, 32'd0);
    run(12);
    req_v = 2'b00;
    run(1);
    check("t3_gnt_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
      check("t3_gnt0", gnt_log[0], 2'b01);
      check("t3_gnt1", gnt_log[1], 2'b10);
      check("t3_gnt2", gnt_log[2], 2'b01);
      check("t3_gnt3", gnt_log[3], 2'b10);
    end

    // Out-of-range stores must leave memory alone.
    txn(0, 1'b1, 32'd64, 32'h12345678);
    txn(1, 1'b1, 32'h8000_0005, 32'hA5A5A5A5);
    txn(0, 1'b0, 32'd63, 32'd0);
    check("t4_word63", RespData, 32'd0);
    txn(0, 1'b0, 32'd0, 32'd0);
    check("t4_word0", RespData, 32'd63);
    txn(1, 1'b0, 32'd5, 32'd0);
    check("t4_word5", RespData, 32'hDEADBEEF);

    // Reset asserted in the ISSUE cycle of a store to address 7.
    set_req(0, 1'b1, 1'b1, 32'd7, 32'hCAFEF00D);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_gnt",   Gnt, 2'b00);
    check("t5_rst_done",  Done, 2'b00);
    check("t5_rst_err",   Err, 2'b00);
    check("t5_rst_resp",  RespData, 32'd0);
    check("t5_rst_busy",  Busy, 1'b0);
    check("t5_rst_addr",  MemAddress, 32'd0);
    check("t5_rst_wr",    MemWrite, 1'b0);
    check("t5_rst_rd",    MemRead, 1'b0);
    check("t5_rst_wdata", MemWriteData, 32'd0);
    model_reset();
    req_v = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    gnt_log.delete();
    set_req(0, 1'b1, 1'b0, 32'd7, 32'd0);
    set_req(1, 1'b1, 1'b0, 32'd1, 32'd0);
    run(2);
    req_v[0] = 1'b0;
    run(4);
    req_v[1] = 1'b0;
    run(2);
    check("t5_first_tie", (gnt_log.size() > 0) ? gnt_log[0] : 2'b00, 2'b01);
    check("t5_word7", RespData, 32'd0);
    txn(0, 1'b0, 32'd7, 32'd0);
    check("t5_word7_again", RespData, 32'd0);

    // Address changed during RESP with Req held: second access uses new address.
    txn(1, 1'b1, 32'd3, 32'h33);
    txn(1, 1'b1, 32'd4, 32'h44);
    set_req(0, 1'b1, 1'b0, 32'd3, 32'd0);
    run(2);
    req_a[0] = 32'd4;
    run(1);
    check("t6_first", RespData, 32'h33);
    run(2);
    req_v[0] = 1'b0;
    run(2);
    check("t6_second", RespData, 32'h44);

    // Random traffic from both requesters.
    auto_mode = 1'b1;
    run(2000);
    auto_mode = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    req_v = 2'b00;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
